// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter slice: FSM state encoding,
// default requester count, grant ID width, requester index constants and
// the round-robin pointer advance helper.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    BUSY  = 2'd2
  } arb_state_t;

  localparam int unsigned NREQ_DEFAULT = 6;
  localparam int unsigned ID_W         = 3;
  localparam int unsigned HOLD_W       = 7;

  // Requester indices: data masters D0..D3, then the two test buses.
  localparam logic [ID_W-1:0] ID_D0  = 3'd0;
  localparam logic [ID_W-1:0] ID_D1  = 3'd1;
  localparam logic [ID_W-1:0] ID_D2  = 3'd2;
  localparam logic [ID_W-1:0] ID_D3  = 3'd3;
  localparam logic [ID_W-1:0] ID_TB0 = 3'd4;
  localparam logic [ID_W-1:0] ID_TB1 = 3'd5;

  // Round-robin pointer for the requester after 'id', wrapping at nreq.
  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id,
                                                input int unsigned     nreq);
    return ((32'(id) + 32'd1) >= nreq) ? '0 : id + 1'b1;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Arbiter <-> bus switch signal bundle.
//   req          : per-requester level request (NREQ bits)
//   sw_idle      : switch is in its IDLE state
//   grant_ack    : switch accepted the grant (1-cycle pulse)
//   txn_done     : switch finished the transaction (1-cycle pulse)
//   grant_valid  : a grant is offered or held
//   grant_id     : index of granted requester (0 when no grant)
//   grant_onehot : one-hot form of grant_id (0 when no grant)
//   timeout      : held grant aborted (1-cycle pulse)
// Modport master is the arbiter side, slave the switch/requester side.
interface bus_arbiter_if
  import bus_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEFAULT
);

  logic [NREQ-1:0] req;
  logic            sw_idle;
  logic            grant_ack;
  logic            txn_done;
  logic            grant_valid;
  logic [ID_W-1:0] grant_id;
  logic [NREQ-1:0] grant_onehot;
  logic            timeout;

  modport master (
    input  req, sw_idle, grant_ack, txn_done,
    output grant_valid, grant_id, grant_onehot, timeout
  );

  modport slave (
    output req, sw_idle, grant_ack, txn_done,
    input  grant_valid, grant_id, grant_onehot, timeout
  );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin search.
//   req       : request vector
//   rr_ptr    : index where the search starts
//   any       : at least one request is set
//   winner_id : first set request at or after rr_ptr, wrapping upward
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEFAULT
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] rr_ptr,
  output logic            any,
  output logic [ID_W-1:0] winner_id
);

  int unsigned w_idx;

  always_comb begin
    any       = 1'b0;
    winner_id = '0;
    w_idx     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = (32'(rr_ptr) + k) % NREQ;
      if (!any && req[w_idx]) begin
        any       = 1'b1;
        winner_id = ID_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with an IDLE/OFFER/BUSY grant FSM and a
// hold-time watchdog that aborts a grant after TIMEOUT BUSY cycles.
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : bus_arbiter_if master modport (requests, switch handshake,
//           registered grant outputs and timeout pulse)
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned NREQ    = NREQ_DEFAULT,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.master bus
);

  arb_state_t      r_state, w_state_nxt;
  logic [ID_W-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [HOLD_W-1:0] r_hold, w_hold_nxt;
  logic            r_grant_valid, w_grant_valid_nxt;
  logic [ID_W-1:0] r_grant_id, w_grant_id_nxt;
  logic [NREQ-1:0] r_grant_onehot, w_grant_onehot_nxt;
  logic            r_timeout, w_timeout_nxt;

  logic            w_any;
  logic [ID_W-1:0] w_winner_id;
  logic            w_start;
  logic            w_req_held;
  logic            w_hold_limit;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req       (bus.req),
    .rr_ptr    (r_rr_ptr),
    .any       (w_any),
    .winner_id (w_winner_id)
  );

  assign w_start      = w_any && bus.sw_idle;
  assign w_req_held   = bus.req[r_grant_id];
  assign w_hold_limit = (r_hold == HOLD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_rr_ptr       <= '0;
      r_hold         <= '0;
      r_grant_valid  <= 1'b0;
      r_grant_id     <= '0;
      r_grant_onehot <= '0;
      r_timeout      <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_rr_ptr       <= w_rr_ptr_nxt;
      r_hold         <= w_hold_nxt;
      r_grant_valid  <= w_grant_valid_nxt;
      r_grant_id     <= w_grant_id_nxt;
      r_grant_onehot <= w_grant_onehot_nxt;
      r_timeout      <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  if (w_start) w_state_nxt = OFFER;
      // grant_ack wins over a simultaneous request drop
      OFFER: if (bus.grant_ack) w_state_nxt = BUSY;
             else if (!w_req_held) w_state_nxt = IDLE;
      BUSY:  if (bus.txn_done || w_hold_limit) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs and datapath; every output is
  // computed here one cycle ahead so the ports come straight from flops.
  always_comb begin
    w_grant_valid_nxt = r_grant_valid;
    w_grant_id_nxt    = r_grant_id;
    w_rr_ptr_nxt      = r_rr_ptr;
    w_hold_nxt        = r_hold;
    w_timeout_nxt     = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_grant_valid_nxt = w_start;
        w_grant_id_nxt    = w_start ? w_winner_id : '0;
      end
      OFFER: begin
        if (bus.grant_ack) begin
          w_hold_nxt = '0;
        end else if (!w_req_held) begin
          w_grant_valid_nxt = 1'b0;
          w_grant_id_nxt    = '0;
        end
      end
      BUSY: begin
        if (bus.txn_done || w_hold_limit) begin
          w_grant_valid_nxt = 1'b0;
          w_grant_id_nxt    = '0;
          w_rr_ptr_nxt      = next_ptr(r_grant_id, NREQ);
          w_timeout_nxt     = !bus.txn_done;
        end else begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end
      default: begin
        w_grant_valid_nxt = 1'b0;
        w_grant_id_nxt    = '0;
      end
    endcase
    w_grant_onehot_nxt = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_grant_onehot_nxt[i] = w_grant_valid_nxt && (w_grant_id_nxt == ID_W'(i));
    end
  end

  assign bus.grant_valid  = r_grant_valid;
  assign bus.grant_id     = r_grant_id;
  assign bus.grant_onehot = r_grant_onehot;
  assign bus.timeout      = r_timeout;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter.
module tb_bus_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  bus_arbiter_if #(.NREQ(6)) bus ();

  bus_arbiter #(.NREQ(6), .TIMEOUT(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset         = 1'b1;
    bus.req       = '0;
    bus.sw_idle   = 1'b1;
    bus.grant_ack = 1'b0;
    bus.txn_done  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", bus.grant_valid); end
    n_checks++;
    if (bus.grant_id !== 3'd0) begin n_fail++; $display("FAIL rst_id got %0d want 0", bus.grant_id); end
    n_checks++;
    if (bus.grant_onehot !== 6'b0) begin n_fail++; $display("FAIL rst_onehot got %b want 000000", bus.grant_onehot); end
    n_checks++;
    if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL rst_timeout got %b want 0", bus.timeout); end
  endtask

  task automatic test_single();
    apply_reset();
    bus.req = 6'b000001;
    tick();
    n_checks++;
    if (bus.grant_valid !== 1'b1 || bus.grant_id !== 3'd0) begin
      n_fail++; $display("FAIL s1_grant got v=%b id=%0d want v=1 id=0", bus.grant_valid, bus.grant_id);
    end
    n_checks++;
    if (bus.grant_onehot !== 6'b000001) begin n_fail++; $display("FAIL s1_onehot got %b want 000001", bus.grant_onehot); end
    bus.grant_ack = 1'b1;
    tick();
    bus.grant_ack = 1'b0;
    repeat (4) tick();
    bus.txn_done = 1'b1;
    tick();
    bus.txn_done = 1'b0;
    n_checks++;
    if (bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL s1_release got %b want 0", bus.grant_valid); end
    // rr_ptr should now be 1: with 0 and 1 requesting, 1 wins
    bus.req = 6'b000011;
    tick();
    n_checks++;
    if (bus.grant_id !== 3'd1) begin n_fail++; $display("FAIL s1_rrptr got %0d want 1", bus.grant_id); end
    bus.req = '0;
    tick();
  endtask

  task automatic test_rr_order();
    logic [2:0] exp_order [5];
    exp_order = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd0};
    apply_reset();
    bus.req = 6'b110011;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (bus.grant_valid !== 1'b1 || bus.grant_id !== exp_order[i]) begin
        n_fail++; $display("FAIL rr_order[%0d] got v=%b id=%0d want v=1 id=%0d", i, bus.grant_valid, bus.grant_id, exp_order[i]);
      end
      bus.grant_ack = 1'b1;
      tick();
      bus.grant_ack = 1'b0;
      bus.txn_done  = 1'b1;
      tick();
      bus.txn_done  = 1'b0;
      n_checks++;
      if (bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL rr_gap[%0d] got %b want 0", i, bus.grant_valid); end
    end
    bus.req = '0;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    int early;
    apply_reset();
    bus.req = 6'b000011;
    tick();
    bus.grant_ack = 1'b1;
    tick();
    bus.grant_ack = 1'b0;
    early = 0;
    for (int i = 0; i < 63; i++) begin
      tick();
      if (bus.timeout !== 1'b0 || bus.grant_valid !== 1'b1) early++;
    end
    n_checks++;
    if (early != 0) begin n_fail++; $display("FAIL to_early got %0d bad cycles want 0", early); end
    tick();
    n_checks++;
    if (bus.timeout !== 1'b1 || bus.grant_valid !== 1'b0) begin
      n_fail++; $display("FAIL to_pulse got to=%b v=%b want to=1 v=0", bus.timeout, bus.grant_valid);
    end
    tick();
    n_checks++;
    if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL to_width got %b want 0", bus.timeout); end
    n_checks++;
    if (bus.grant_id !== 3'd1 || bus.grant_valid !== 1'b1) begin
      n_fail++; $display("FAIL to_rrptr got v=%b id=%0d want v=1 id=1", bus.grant_valid, bus.grant_id);
    end
    bus.req = '0;
    tick();
  endtask

  task automatic test_offer_drop();
    apply_reset();
    bus.req = 6'b000100;
    tick();
    n_checks++;
    if (bus.grant_id !== 3'd2 || bus.grant_onehot !== 6'b000100) begin
      n_fail++; $display("FAIL od_grant got id=%0d oh=%b want id=2 oh=000100", bus.grant_id, bus.grant_onehot);
    end
    bus.req = 6'b001100;
    tick();
    n_checks++;
    if (bus.grant_id !== 3'd2 || bus.grant_valid !== 1'b1) begin
      n_fail++; $display("FAIL od_stable got v=%b id=%0d want v=1 id=2", bus.grant_valid, bus.grant_id);
    end
    bus.req = 6'b001000;
    tick();
    n_checks++;
    if (bus.grant_valid !== 1'b0 || bus.grant_id !== 3'd0 || bus.grant_onehot !== 6'b0) begin
      n_fail++; $display("FAIL od_drop got v=%b id=%0d oh=%b want v=0 id=0 oh=0", bus.grant_valid, bus.grant_id, bus.grant_onehot);
    end
    // pointer must still be 0, so 2 beats 3
    bus.req = 6'b001100;
    tick();
    n_checks++;
    if (bus.grant_id !== 3'd2) begin n_fail++; $display("FAIL od_regrant got %0d want 2", bus.grant_id); end
    bus.req       = 6'b001000;
    bus.grant_ack = 1'b1;
    tick();
    bus.grant_ack = 1'b0;
    tick();
    n_checks++;
    if (bus.grant_valid !== 1'b1 || bus.grant_id !== 3'd2) begin
      n_fail++; $display("FAIL od_ackwins got v=%b id=%0d want v=1 id=2", bus.grant_valid, bus.grant_id);
    end
    bus.txn_done = 1'b1;
    tick();
    bus.txn_done = 1'b0;
    bus.req = '0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_busy();
    apply_reset();
    bus.req = 6'b001000;
    tick();
    bus.grant_ack = 1'b1;
    tick();
    bus.grant_ack = 1'b0;
    repeat (2) tick();
    #3 reset = 1'b1;
    #1;
    n_checks++;
    if (bus.grant_valid !== 1'b0 || bus.grant_id !== 3'd0 || bus.grant_onehot !== 6'b0 || bus.timeout !== 1'b0) begin
      n_fail++; $display("FAIL rb_async got v=%b id=%0d oh=%b to=%b want all 0", bus.grant_valid, bus.grant_id, bus.grant_onehot, bus.timeout);
    end
    #1 reset = 1'b0;
    tick();
    n_checks++;
    if (bus.grant_valid !== 1'b1 || bus.grant_id !== 3'd3) begin
      n_fail++; $display("FAIL rb_after got v=%b id=%0d want v=1 id=3", bus.grant_valid, bus.grant_id);
    end
    bus.req = '0;
    tick();
  endtask

  task automatic test_done_at_limit();
    apply_reset();
    bus.req = 6'b000011;
    tick();
    bus.grant_ack = 1'b1;
    tick();
    bus.grant_ack = 1'b0;
    repeat (63) tick();
    bus.txn_done = 1'b1;
    tick();
    bus.txn_done = 1'b0;
    n_checks++;
    if (bus.timeout !== 1'b0 || bus.grant_valid !== 1'b0) begin
      n_fail++; $display("FAIL dl_done got to=%b v=%b want to=0 v=0", bus.timeout, bus.grant_valid);
    end
    tick();
    n_checks++;
    if (bus.timeout !== 1'b0 || bus.grant_id !== 3'd1 || bus.grant_valid !== 1'b1) begin
      n_fail++; $display("FAIL dl_next got to=%b v=%b id=%0d want to=0 v=1 id=1", bus.timeout, bus.grant_valid, bus.grant_id);
    end
    bus.req = '0;
    tick();
  endtask

  task automatic test_sw_idle_block();
    int bad;
    apply_reset();
    bus.sw_idle = 1'b0;
    bus.req     = 6'b000010;
    bad = 0;
    repeat (3) begin
      tick();
      if (bus.grant_valid !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL sw_block got %0d grants want 0", bad); end
    bus.sw_idle = 1'b1;
    tick();
    n_checks++;
    if (bus.grant_valid !== 1'b1 || bus.grant_id !== 3'd1) begin
      n_fail++; $display("FAIL sw_release got v=%b id=%0d want v=1 id=1", bus.grant_valid, bus.grant_id);
    end
    bus.req = '0;
    tick();
  endtask

  task automatic test_idle_pulses();
    apply_reset();
    bus.grant_ack = 1'b1;
    bus.txn_done  = 1'b1;
    tick();
    bus.grant_ack = 1'b0;
    bus.txn_done  = 1'b0;
    n_checks++;
    if (bus.grant_valid !== 1'b0 || bus.timeout !== 1'b0) begin
      n_fail++; $display("FAIL ip_ignore got v=%b to=%b want 0 0", bus.grant_valid, bus.timeout);
    end
    bus.req = 6'b000011;
    tick();
    n_checks++;
    if (bus.grant_id !== 3'd0 || bus.grant_valid !== 1'b1) begin
      n_fail++; $display("FAIL ip_ptr got v=%b id=%0d want v=1 id=0", bus.grant_valid, bus.grant_id);
    end
    bus.req = '0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_rr_order();
    test_timeout();
    test_offer_drop();
    test_reset_mid_busy();
    test_done_at_limit();
    test_sw_idle_block();
    test_idle_pulses();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 6, giving the number of requesters: index 0-3 for D0-D3, 4 for TB0, 5 for TB1.
REQ-002 The block SHALL have parameter TIMEOUT, default 64, giving the maximum BUSY cycles before the grant is aborted.
REQ-003 clk  input  1  the single clock; all state SHALL change on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  NREQ  per-requester level request; bit i SHALL be the OR of that master's reqout bits.
REQ-006 sw_idle  input  1  high when the bus switch is in its IDLE state.
REQ-007 grant_ack  input  1  one-cycle pulse from the switch when it accepts the grant.
REQ-008 txn_done  input  1  one-cycle pulse from the switch when it returns to IDLE after the response.
REQ-009 grant_valid  output  1  high while a grant is offered or held.
REQ-010 grant_id  output  3  index of the granted requester; 0 when grant_valid is low.
REQ-011 grant_onehot  output  NREQ  one-hot form of grant_id; all zero when grant_valid is low.
REQ-012 timeout  output  1  one-cycle pulse when a held grant is aborted.

Function
REQ-013 The FSM SHALL have three states: IDLE, OFFER, BUSY.
REQ-014 IDLE: when any req bit is high and sw_idle=1, the block SHALL register the winner into grant_id, set grant_valid=1 and go to OFFER on the next edge.
- Latency from req to grant_valid: 1 cycle.
REQ-015 The winner SHALL be the first set req bit at or after rr_ptr, searching upward and wrapping from NREQ-1 to 0.
REQ-016 OFFER: grant_ack=1 SHALL go to BUSY.
- If req[grant_id] drops before grant_ack arrives, the block SHALL return to IDLE with grant_valid=0 and rr_ptr unchanged.
- If both happen in the same cycle, grant_ack SHALL win.
REQ-017 BUSY: grant_id and grant_valid SHALL stay stable until txn_done=1. The block SHALL then go to IDLE, clear grant_valid and set rr_ptr = (grant_id+1) mod NREQ.
REQ-018 A 7-bit hold counter SHALL be cleared on entry to BUSY and increment every BUSY cycle.
- When it reaches TIMEOUT-1 and txn_done=0, the block SHALL pulse timeout for 1 cycle, go to IDLE, clear grant_valid and advance rr_ptr as in REQ-017.
REQ-019 If txn_done and the timeout condition occur in the same cycle, txn_done SHALL take priority and timeout SHALL stay 0.
REQ-020 Changes on req SHALL NOT alter grant_id while in OFFER or BUSY.
REQ-021 No new grant SHALL be issued while sw_idle=0, even in IDLE.
REQ-022 Back-to-back transactions: the earliest new grant_valid SHALL be the cycle after the IDLE cycle that follows txn_done. The block SHALL idle for at least 1 cycle between grants.
REQ-023 grant_ack or txn_done received in IDLE SHALL be ignored.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 On reset the block SHALL asynchronously force: state=IDLE, rr_ptr=0, hold counter=0, grant_valid=0, grant_id=0, grant_onehot=0, timeout=0.
REQ-026 Reset asserted in OFFER or BUSY SHALL drop the grant immediately, with no timeout pulse.
- After release, the first grant SHALL follow REQ-015 from rr_ptr=0.

Structure
REQ-027 A shared package bus_arb_pkg SHALL hold: the arb_state_t enum (IDLE, OFFER, BUSY), the NREQ default, the ID width constant (3) and the requester index constants (D0..D3, TB0, TB1).
REQ-028 The round-robin search SHALL be a combinational sub-module rr_pick with inputs req and rr_ptr and outputs any and winner_id, instantiated once.

Verification
REQ-029 Scenario 1: reset, then req=6'b000001, sw_idle=1 -> grant_valid=1 and grant_id=0 one cycle later. grant_ack, then txn_done 5 cycles later -> grant_valid=0 and rr_ptr=1.
REQ-030 Scenario 2: req=6'b110011 held, every grant acked and completed -> grant order 0,1,4,5,0.
REQ-031 Scenario 3: grant_ack given, txn_done never sent, TIMEOUT=64 -> timeout pulses exactly 64 BUSY cycles after entry, then grant_valid=0.
REQ-032 Scenario 4: granted id 2 in OFFER, req[2] drops with no grant_ack -> back to IDLE, next grant with req=6'b000100 is again id 2.
REQ-033 Scenario 5: reset asserted mid-BUSY with grant_id=3 -> all outputs 0 immediately. After release with req=6'b001000 -> grant_id=3.
REQ-034 Scenario 6: txn_done on the 64th BUSY cycle -> timeout stays 0 and rr_ptr advances.
